// File: rtl/rf_wb_ctrl_pkg.sv
// Shared CPU-level definitions used by the register-file write-back path.
// Holds the register-file input mux encoding, the write-back controller
// state encoding and the default memory-ack wait limit.
package cpu_common;

  // Register-file input mux legs
  typedef enum logic [1:0] {
    RF_SRC_IMM = 2'd0,
    RF_SRC_R0  = 2'd1,
    RF_SRC_ALU = 2'd2,
    RF_SRC_MEM = 2'd3
  } rf_mux_src_t;

  // Write-back controller states
  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_MEM_REQ   = 2'd1,
    WB_MEM_WRITE = 2'd2,
    WB_ERROR     = 2'd3
  } wb_state_t;

  localparam int unsigned WB_TIMEOUT_CYCLES_DEFAULT = 32'd16;
  localparam int unsigned RF_ADDR_W                 = 32'd3;
  localparam int unsigned RF_DATA_W                 = 32'd8;

  // Copying R0 onto itself changes nothing, so such a write is dropped.
  function automatic logic is_self_copy(input rf_mux_src_t src, input logic [2:0] addr);
    return (src == RF_SRC_R0) && (addr == 3'd0);
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Write-back controller bus: decoder request handshake, memory read port
// and register-file write port. master = decoder/memory side, slave =
// controller side.
interface rf_wb_ctrl_if;
  import cpu_common::*;

  logic        wb_valid;
  rf_mux_src_t wb_src;
  logic [2:0]  wb_addr;
  logic        wb_ready;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic [7:0]  mem_data_hold;
  rf_mux_src_t rf_mux_src;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic        wb_error;

  modport master (
    output wb_valid, wb_src, wb_addr, mem_rd_ack, mem_rd_data,
    input  wb_ready, mem_rd_req, mem_data_hold, rf_mux_src, rf_we, rf_waddr, wb_error
  );

  modport slave (
    input  wb_valid, wb_src, wb_addr, mem_rd_ack, mem_rd_data,
    output wb_ready, mem_rd_req, mem_data_hold, rf_mux_src, rf_we, rf_waddr, wb_error
  );

endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller.
// Non-memory write-backs retire one cycle after acceptance at one per cycle;
// memory write-backs issue a read, wait for the ack, capture the data and
// write it through the MEM mux leg in the following cycle.
// Optional feature macro: RF_WB_CTRL_MEM_TIMEOUT_EN -- bounds the ack wait to
// TIMEOUT_CYCLES and parks the controller in a sticky error state on expiry.
module rf_wb_ctrl
  import cpu_common::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_async_n,
  rf_wb_ctrl_if.slave bus
);

  if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > 32'd255)) begin : g_timeout_range
    $error("rf_wb_ctrl: TIMEOUT_CYCLES must be within 2..255");
  end

  wb_state_t   state_r;
  wb_state_t   state_nxt_s;
  logic        ready_r;
  logic        mem_rd_req_r;
  logic        rf_we_r;
  rf_mux_src_t rf_mux_src_r;
  logic [2:0]  rf_waddr_r;
  logic [2:0]  mem_addr_r;
  logic [7:0]  mem_data_hold_r;

  logic        accept_s;
  logic        accept_mem_s;
  logic        direct_write_s;
  logic        ack_capture_s;
  logic        timeout_hit_s;

  // Request handshake and memory-ack qualification
  always_comb begin
    accept_s       = bus.wb_valid && (state_r == WB_IDLE);
    accept_mem_s   = accept_s && (bus.wb_src == RF_SRC_MEM);
    direct_write_s = accept_s && (bus.wb_src != RF_SRC_MEM)
                     && !is_self_copy(bus.wb_src, bus.wb_addr);
    ack_capture_s  = (state_r == WB_MEM_REQ) && bus.mem_rd_ack;
  end

`ifdef RF_WB_CTRL_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt_r;
  logic       wb_error_r;

  // Expiry fires on the wait cycle that would bring the count to the limit;
  // an ack in that same cycle takes precedence.
  always_comb begin
    if ((state_r == WB_MEM_REQ) && !bus.mem_rd_ack && ((tmo_cnt_r + 8'd1) == TIMEOUT_LIMIT)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Count unacknowledged read-wait cycles; cleared whenever not waiting
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == WB_MEM_REQ) && !bus.mem_rd_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= 8'd0;
    end
  end

  // Sticky timeout flag, only reset clears it
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wb_error_r <= 1'b0;
    end else if (timeout_hit_s) begin
      wb_error_r <= 1'b1;
    end else begin
      wb_error_r <= wb_error_r;
    end
  end

  assign bus.wb_error = wb_error_r;
`else
  assign timeout_hit_s = 1'b0;
  assign bus.wb_error  = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WB_IDLE: begin
        if (accept_mem_s) begin
          state_nxt_s = WB_MEM_REQ;
        end else begin
          state_nxt_s = WB_IDLE;
        end
      end
      WB_MEM_REQ: begin
        if (bus.mem_rd_ack) begin
          state_nxt_s = WB_MEM_WRITE;
        end else if (timeout_hit_s) begin
          state_nxt_s = WB_ERROR;
        end else begin
          state_nxt_s = WB_MEM_REQ;
        end
      end
      WB_MEM_WRITE: begin
        state_nxt_s = WB_IDLE;
      end
      WB_ERROR: begin
`ifdef RF_WB_CTRL_MEM_TIMEOUT_EN
        state_nxt_s = WB_ERROR;
`else
        state_nxt_s = WB_IDLE;
`endif
      end
      default: begin
        state_nxt_s = WB_IDLE;
      end
    endcase
  end

  // State register plus ready/read-request flags decoded from the next state
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_r      <= WB_IDLE;
      ready_r      <= 1'b1;
      mem_rd_req_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ready_r      <= (state_nxt_s == WB_IDLE);
      mem_rd_req_r <= (state_nxt_s == WB_MEM_REQ);
    end
  end

  // Destination of an outstanding memory write-back
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      mem_addr_r <= 3'd0;
    end else if (accept_mem_s) begin
      mem_addr_r <= bus.wb_addr;
    end else begin
      mem_addr_r <= mem_addr_r;
    end
  end

  // Register-file write port; select and address hold while idle
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      rf_we_r      <= 1'b0;
      rf_mux_src_r <= RF_SRC_IMM;
      rf_waddr_r   <= 3'd0;
    end else if (direct_write_s) begin
      rf_we_r      <= 1'b1;
      rf_mux_src_r <= bus.wb_src;
      rf_waddr_r   <= bus.wb_addr;
    end else if (ack_capture_s) begin
      rf_we_r      <= 1'b1;
      rf_mux_src_r <= RF_SRC_MEM;
      rf_waddr_r   <= mem_addr_r;
    end else begin
      rf_we_r      <= 1'b0;
      rf_mux_src_r <= rf_mux_src_r;
      rf_waddr_r   <= rf_waddr_r;
    end
  end

  // Memory data capture; acks outside the read wait are ignored
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      mem_data_hold_r <= 8'h00;
    end else if (ack_capture_s) begin
      mem_data_hold_r <= bus.mem_rd_data;
    end else begin
      mem_data_hold_r <= mem_data_hold_r;
    end
  end

  assign bus.wb_ready      = ready_r;
  assign bus.mem_rd_req    = mem_rd_req_r;
  assign bus.rf_we         = rf_we_r;
  assign bus.rf_mux_src    = rf_mux_src_r;
  assign bus.rf_waddr      = rf_waddr_r;
  assign bus.mem_data_hold = mem_data_hold_r;

endmodule
